fifo_buffer: RTL

- Synchronous single-clock FIFO: the storage element fed and drained by the two-FIFO ping-pong controller.
- Accepts the controller's write enable, read enable and reset.
- Returns full/empty status that the controller decodes.
- One instance per FIFO slot (FIFO_1, FIFO_2); data path is WIDTH bits wide, DEPTH entries deep.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_buffer_if.sv | 41 ++++
 rtl/fifo_mem.sv | 45 ++++
 rtl/fifo_buffer.sv | 90 +++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the ping-pong FIFO slots and their controller.
package fifo_pkg;

   localparam int unsigned FIFO_WIDTH_DEF = 8;
   localparam int unsigned FIFO_DEPTH_DEF = 16;

   typedef struct packed {
      logic full;
      logic empty;
   } fifo_status_t;

   // Pointers carry a wrap bit above addr_w index bits; full means same slot, opposite lap.
   function automatic logic ptr_full(input int unsigned wr, input int unsigned rd,
                                     input int unsigned addr_w);
      int unsigned mask;
      mask = (32'd2 << addr_w) - 32'd1;
      return ((wr ^ rd) & mask) == (32'd1 << addr_w);
   endfunction

endpackage

// File: rtl/fifo_buffer_if.sv
// Handshake/data bundle between the ping-pong controller (master) and a FIFO slot (slave).
// FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow status signals.
interface fifo_buffer_if
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic              WrEn;
   logic              RdEn;
   logic [WIDTH-1:0]  DataIn;
   logic [WIDTH-1:0]  DataOut;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
   logic              overflow;
   logic              underflow;

   modport master (
      output WrEn, RdEn, DataIn,
      input  DataOut, full, empty, count, overflow, underflow
   );
   modport slave (
      input  WrEn, RdEn, DataIn,
      output DataOut, full, empty, count, overflow, underflow
   );
`else
   modport master (
      output WrEn, RdEn, DataIn,
      input  DataOut, full, empty, count
   );
   modport slave (
      input  WrEn, RdEn, DataIn,
      output DataOut, full, empty, count
   );
`endif

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port DEPTH x WIDTH RAM: synchronous write, registered read.
// Only the read register is reset; the array holds don't-care data after reset.
module fifo_mem #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q, rdata_d;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Same-edge write to the slot being read returns the old word.
   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         rdata_d = mem_q[raddr_i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_buffer.sv
// Single-clock FIFO slot: pointers, flags and accept logic around fifo_mem.
// Define FIFO_ERR_FLAGS_EN for sticky overflow/underflow outputs.
module fifo_buffer
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input logic          clk,
   input logic          reset,
   fifo_buffer_if.slave bus
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             wr_ok, rd_ok;
   fifo_status_t     status;

   always_comb begin
      status.empty = (wr_ptr_q == rd_ptr_q);
      status.full  = ptr_full(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_W);
      // A write into a full FIFO is fine when a read frees a slot on the same edge.
      wr_ok    = bus.WrEn & (~status.full | bus.RdEn);
      rd_ok    = bus.RdEn & ~status.empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   fifo_mem #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .we_i    (wr_ok),
      .waddr_i (wr_ptr_q[ADDR_W-1:0]),
      .wdata_i (bus.DataIn),
      .re_i    (rd_ok),
      .raddr_i (rd_ptr_q[ADDR_W-1:0]),
      .rdata_o (bus.DataOut)
   );

   assign bus.full  = status.full;
   assign bus.empty = status.empty;
   assign bus.count = wr_ptr_q - rd_ptr_q;

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q | (bus.WrEn & ~wr_ok);
      underflow_d = underflow_q | (bus.RdEn & ~rd_ok);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif

endmodule
